// File: rtl/writeback_arbiter_if.sv
// writeback_arbiter_if: ALU/load result inputs and register-file write port of writeback_arbiter.
interface writeback_arbiter_if;
    logic        alu_valid;
    logic [3:0]  alu_addr;
    logic [31:0] alu_data;
    logic        mem_valid;
    logic        mem_ready;
    logic [3:0]  mem_addr;
    logic [31:0] mem_data;
    logic        writeEnable;
    logic [3:0]  writeAddr;
    logic [31:0] writeData;
    logic        stall_out;
    logic        illegal_wr;
    modport master (
        output alu_valid, alu_addr, alu_data, mem_valid, mem_addr, mem_data,
        input  mem_ready, writeEnable, writeAddr, writeData, stall_out, illegal_wr
    );
    modport slave (
        input  alu_valid, alu_addr, alu_data, mem_valid, mem_addr, mem_data,
        output mem_ready, writeEnable, writeAddr, writeData, stall_out, illegal_wr
    );
endinterface

// File: rtl/writeback_arbiter.sv
// writeback_arbiter: merges ALU results and FIFO-buffered load results onto the register-file write port.
// Defining WB_PERF_EN adds the stall_cycles and illegal_count counters.
module writeback_arbiter #(
    parameter int FIFO_DEPTH   = 4,
    parameter int STARVE_LIMIT = 3
) (
    input  logic               clk,
    input  logic               reset,
    writeback_arbiter_if.slave bus
`ifdef WB_PERF_EN
    ,
    output logic [15:0]        stall_cycles,
    output logic [7:0]         illegal_count
`endif
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int SW = $clog2(STARVE_LIMIT + 1);
    localparam logic [AW:0]   DEPTH = (AW + 1)'(FIFO_DEPTH);
    localparam logic [SW-1:0] LIMIT = SW'(STARVE_LIMIT);

    logic [35:0]   fifo_q [FIFO_DEPTH];
    logic [AW:0]   wr_q, wr_d, rd_q, rd_d, cnt_d;
    logic [SW-1:0] starve_q, starve_d;
    logic          stall_q, stall_d, we_q, we_d, ill_q, ill_d;
    logic [3:0]    addr_q, addr_d, sel_addr;
    logic [31:0]   data_q, data_d, sel_data;
    logic          full, head, push, pop, alu_win, sel;

    always_comb begin
        full     = (wr_q - rd_q) == DEPTH;
        head     = wr_q != rd_q;
        push     = bus.mem_valid && !full;
        alu_win  = bus.alu_valid && !stall_q;
        pop      = head && !alu_win;
        sel      = alu_win || pop;
        sel_addr = alu_win ? bus.alu_addr : fifo_q[rd_q[AW-1:0]][35:32];
        sel_data = alu_win ? bus.alu_data : fifo_q[rd_q[AW-1:0]][31:0];
        wr_d     = wr_q + (AW + 1)'(push);
        rd_d     = rd_q + (AW + 1)'(pop);
        cnt_d    = wr_d - rd_d;
        starve_d = (!head || pop) ? '0 : (starve_q == LIMIT ? starve_q : starve_q + 1'b1);
        stall_d  = cnt_d == DEPTH || starve_d == LIMIT;
        we_d     = sel && sel_addr < 4'd9;
        ill_d    = sel && sel_addr >= 4'd9;
        addr_d   = we_d ? sel_addr : addr_q;
        data_d   = we_d ? sel_data : data_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_q     <= '0;
            rd_q     <= '0;
            starve_q <= '0;
            stall_q  <= 1'b0;
            we_q     <= 1'b0;
            ill_q    <= 1'b0;
            addr_q   <= '0;
            data_q   <= '0;
        end else begin
            wr_q     <= wr_d;
            rd_q     <= rd_d;
            starve_q <= starve_d;
            stall_q  <= stall_d;
            we_q     <= we_d;
            ill_q    <= ill_d;
            addr_q   <= addr_d;
            data_q   <= data_d;
        end
        // Storage needs no reset: the pointers define which slots are live.
        if (push) fifo_q[wr_q[AW-1:0]] <= {bus.mem_addr, bus.mem_data};
    end

    assign bus.mem_ready   = !full;
    assign bus.writeEnable = we_q;
    assign bus.writeAddr   = addr_q;
    assign bus.writeData   = data_q;
    assign bus.stall_out   = stall_q;
    assign bus.illegal_wr  = ill_q;

`ifdef WB_PERF_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            stall_cycles  <= '0;
            illegal_count <= '0;
        end else begin
            if (stall_q && stall_cycles != '1) stall_cycles <= stall_cycles + 1'b1;
            if (ill_q && illegal_count != '1) illegal_count <= illegal_count + 1'b1;
        end
    end
`endif
endmodule

// File: tb/tb_writeback_arbiter.sv
// tb_writeback_arbiter: directed scenarios plus random traffic checked against a queue-based reference model.
module tb_writeback_arbiter;
    localparam int DEPTH = 4;
    localparam int LIMIT = 3;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   checks = 0;
    int   failures = 0;
`ifdef WB_PERF_EN
    logic [15:0] stall_cycles;
    logic [7:0]  illegal_count;
    int          m_sc = 0;
    int          m_ic = 0;
`endif

    logic [35:0] q[$];
    int          starve = 0;
    logic        m_stall = 1'b0, m_we = 1'b0, m_ill = 1'b0;
    logic [3:0]  m_addr = '0;
    logic [31:0] m_data = '0;

    writeback_arbiter_if bus ();

    writeback_arbiter #(.FIFO_DEPTH(DEPTH), .STARVE_LIMIT(LIMIT)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
`ifdef WB_PERF_EN
        ,
        .stall_cycles  (stall_cycles),
        .illegal_count (illegal_count)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h expected=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic drive(input logic av, input logic [3:0] aa, input logic [31:0] ad,
                         input logic mv, input logic [3:0] ma, input logic [31:0] md);
        bus.alu_valid = av;
        bus.alu_addr  = aa;
        bus.alu_data  = ad;
        bus.mem_valid = mv;
        bus.mem_addr  = ma;
        bus.mem_data  = md;
    endtask

    task automatic do_reset(input int n);
        drive(0, 0, 0, 0, 0, 0);
        reset = 1'b1;
        repeat (n) begin
            @(posedge clk);
            #1;
            check("rst_we", bus.writeEnable, 0);
            check("rst_ill", bus.illegal_wr, 0);
            check("rst_stall", bus.stall_out, 0);
            check("rst_addr", bus.writeAddr, 0);
            check("rst_data", bus.writeData, 0);
        end
        reset = 1'b0;
        q.delete();
        starve = 0;
        m_stall = 0;
        m_we = 0;
        m_ill = 0;
`ifdef WB_PERF_EN
        m_sc = 0;
        m_ic = 0;
`endif
    endtask

    task automatic step(input logic av, input logic [3:0] aa, input logic [31:0] ad,
                        input logic mv, input logic [3:0] ma, input logic [31:0] md);
        logic        win, pop, acc, had;
        logic [35:0] sel;
        drive(av, aa, ad, mv, ma, md);
        check("mem_ready", bus.mem_ready, q.size() < DEPTH);
        had = q.size() != 0;
        acc = mv && q.size() < DEPTH;
        win = av && !m_stall;
        pop = had && !win;
        sel = win ? {aa, ad} : (pop ? q[0] : 36'd0);
        if (pop) void'(q.pop_front());
        if (acc) q.push_back({ma, md});
        starve = (pop || !had) ? 0 : (starve < LIMIT ? starve + 1 : starve);
`ifdef WB_PERF_EN
        if (m_stall && m_sc < 65535) m_sc++;
        if (m_ill && m_ic < 255) m_ic++;
`endif
        m_stall = q.size() == DEPTH || starve >= LIMIT;
        m_we  = (win || pop) && sel[35:32] < 9;
        m_ill = (win || pop) && sel[35:32] >= 9;
        if (m_we) {m_addr, m_data} = sel;
        @(posedge clk);
        #1;
        check("we", bus.writeEnable, m_we);
        check("ill", bus.illegal_wr, m_ill);
        check("stall", bus.stall_out, m_stall);
        if (m_we) begin
            check("addr", bus.writeAddr, m_addr);
            check("data", bus.writeData, m_data);
        end
`ifdef WB_PERF_EN
        check("stall_cycles", stall_cycles, m_sc);
        check("illegal_count", illegal_count, m_ic);
`endif
    endtask

    task automatic idle();
        step(0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        drive(0, 0, 0, 0, 0, 0);
        do_reset(2);
        step(1, 3, 32'hDEADBEEF, 0, 0, 0);
        check("t1_we", bus.writeEnable, 1);
        check("t1_addr", bus.writeAddr, 3);
        check("t1_data", bus.writeData, 32'hDEADBEEF);
        idle();
        check("t1_one_cycle", bus.writeEnable, 0);

        step(1, 2, 32'h11, 1, 5, 32'h22);
        check("col_alu_addr", bus.writeAddr, 2);
        check("col_alu_data", bus.writeData, 32'h11);
        idle();
        check("col_mem_we", bus.writeEnable, 1);
        check("col_mem_addr", bus.writeAddr, 5);
        check("col_mem_data", bus.writeData, 32'h22);
        idle();

        step(0, 0, 0, 1, 4, 32'h44);
        step(1, 1, 32'hA1, 0, 0, 0);
        step(1, 1, 32'hA2, 0, 0, 0);
        check("starve_pre", bus.stall_out, 0);
        step(1, 1, 32'hA3, 0, 0, 0);
        check("starve_stall", bus.stall_out, 1);
        idle();
        check("starve_addr", bus.writeAddr, 4);
        check("starve_data", bus.writeData, 32'h44);
        idle();

        do_reset(1);
        for (int i = 0; i < 4; i++) step(1, 1, 32'(i), 1, 6, 32'(100 + i));
        check("full_ready", bus.mem_ready, 0);
        check("full_stall", bus.stall_out, 1);
        step(0, 0, 0, 1, 7, 32'h55);
        step(0, 0, 0, 1, 7, 32'h55);
        repeat (6) idle();

        step(1, 9, 32'h99, 0, 0, 0);
        check("ill_alu", bus.illegal_wr, 1);
        step(0, 0, 0, 1, 15, 32'hFF);
        check("ill_gap", bus.illegal_wr, 0);
        idle();
        check("ill_mem", bus.illegal_wr, 1);
        check("ill_mem_we", bus.writeEnable, 0);
        idle();
        check("ill_ready", bus.mem_ready, 1);

        for (int i = 0; i < 3; i++) step(1, 1, 32'(i), 1, 2, 32'(200 + i));
        do_reset(1);
        repeat (4) idle();
        check("mid_ready", bus.mem_ready, 1);
        check("mid_stall", bus.stall_out, 0);
`ifdef WB_PERF_EN
        check("mid_stall_cycles", stall_cycles, 0);
`endif

        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 99) == 0) do_reset(1);
            else step(m_stall ? ($urandom_range(0, 19) == 0) : ($urandom_range(0, 9) < 6),
                      4'($urandom_range(0, 10)), $urandom, 1'($urandom_range(0, 1)),
                      4'($urandom_range(0, 10)), $urandom);
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
